// File: rtl/enc_dec_pkg.sv
// Shared constants, codeword layout helpers and decode status type for the
// 32-bit extended-Hamming (SECDED) encode/decode path.
package enc_dec_pkg;

  localparam int CODE_W  = 32;
  localparam int DATA_W  = 26;
  localparam int SYN_W   = 5;
  localparam int N_CHECK = 5;

  localparam int CHECK_POS [N_CHECK] = '{1, 2, 4, 8, 16};

  typedef enum logic [1:0] {
    CLEAN = 2'd0,
    CORR  = 2'd1,
    UERR  = 2'd2
  } dec_status_e;

  function automatic logic is_check_pos(input int pos);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < N_CHECK; k++) begin
      if (CHECK_POS[k] == pos) hit = 1'b1;
    end
    return hit;
  endfunction

  // Data bits fill the non-check Hamming positions 1..31 in ascending order.
  function automatic int data_pos(input int idx);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 1; p < CODE_W; p++) begin
      if (!is_check_pos(p)) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/dec_syndrome_32.sv
// Combinational syndrome and overall-parity generator for a 32-bit
// extended-Hamming codeword.
module dec_syndrome_32
  import enc_dec_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [SYN_W-1:0]  syn_o,
  output logic              par_o
);

  always_comb begin
    syn_o = '0;
    for (int i = 1; i < CODE_W; i++) begin
      if (code_i[i]) syn_o = syn_o ^ SYN_W'(i);
    end
    par_o = ^code_i;
  end

endmodule

// File: rtl/dec_secded_32.sv
// Two-stage pipelined SECDED decoder with global-stall valid/ready flow
// control and saturating corrected/uncorrectable error counters.
module dec_secded_32
  import enc_dec_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_corr,
  output logic              out_uerr,
  output logic [SYN_W-1:0]  out_pos,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uerr_cnt
);

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both high; a valid producer holds its payload until that edge.
  logic adv;
  logic hs;

  logic [SYN_W-1:0] syn_d;
  logic             par_d;

  logic              s1_valid_q;
  logic [CODE_W-1:0] s1_code_q;
  logic [SYN_W-1:0]  s1_syn_q;
  logic              s1_par_q;
  logic              s1_en_q;

  dec_status_e       status_d;
  logic [CODE_W-1:0] fixed_d;
  logic [DATA_W-1:0] data_d;
  logic              corr_d;
  logic              uerr_d;
  logic [SYN_W-1:0]  pos_d;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_corr_q;
  logic              out_uerr_q;
  logic [SYN_W-1:0]  out_pos_q;

  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] uerr_cnt_q, uerr_cnt_d;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign hs       = out_valid_q && out_ready;

  dec_syndrome_32 u_syn (
    .code_i (in_code),
    .syn_o  (syn_d),
    .par_o  (par_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
      s1_en_q    <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s1_code_q  <= in_code;
      s1_syn_q   <= syn_d;
      s1_par_q   <= par_d;
      s1_en_q    <= en;
    end
  end

  // S=0,P=1 is a flipped overall-parity bit: corrected, but no data bit moves.
  always_comb begin
    status_d = CLEAN;
    if (s1_en_q) begin
      if (s1_par_q)              status_d = CORR;
      else if (s1_syn_q != '0)   status_d = UERR;
    end
    fixed_d = s1_code_q;
    if (status_d == CORR && s1_syn_q != '0) begin
      fixed_d[s1_syn_q] = ~s1_code_q[s1_syn_q];
    end
    for (int d = 0; d < DATA_W; d++) begin
      data_d[d] = fixed_d[SYN_W'(data_pos(d))];
    end
    corr_d = (status_d == CORR);
    uerr_d = (status_d == UERR);
    pos_d  = corr_d ? s1_syn_q : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_corr_q  <= 1'b0;
      out_uerr_q  <= 1'b0;
      out_pos_q   <= '0;
    end else if (adv) begin
      out_valid_q <= s1_valid_q;
      out_data_q  <= data_d;
      out_corr_q  <= corr_d;
      out_uerr_q  <= uerr_d;
      out_pos_q   <= pos_d;
    end
  end

  // Clear has priority over a same-cycle increment.
  always_comb begin
    corr_cnt_d = corr_cnt_q;
    uerr_cnt_d = uerr_cnt_q;
    if (cnt_clr) begin
      corr_cnt_d = '0;
      uerr_cnt_d = '0;
    end else if (hs) begin
      if (out_corr_q && corr_cnt_q != '1) corr_cnt_d = corr_cnt_q + CNT_W'(1);
      if (out_uerr_q && uerr_cnt_q != '1) uerr_cnt_d = uerr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt_q <= '0;
      uerr_cnt_q <= '0;
    end else begin
      corr_cnt_q <= corr_cnt_d;
      uerr_cnt_q <= uerr_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_corr  = out_corr_q;
  assign out_uerr  = out_uerr_q;
  assign out_pos   = out_pos_q;
  assign corr_cnt  = corr_cnt_q;
  assign uerr_cnt  = uerr_cnt_q;

endmodule

// File: tb/tb_dec_secded_32.sv
// Bench for dec_secded_32: directed and random codewords checked against a
// nearest-codeword reference decoder, plus flow-control and counter checks.
module tb_dec_secded_32;

  localparam int EXP_W = 33;  // {data[25:0], corr, uerr, pos[4:0]}

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic [31:0] in_code;
  logic        out_ready;
  logic        cnt_clr;

  logic        in_ready, out_valid, out_corr, out_uerr;
  logic [25:0] out_data;
  logic [4:0]  out_pos;
  logic [15:0] corr_cnt, uerr_cnt;

  logic        b_in_ready, b_out_valid, b_out_corr, b_out_uerr;
  logic [25:0] b_out_data;
  logic [4:0]  b_out_pos;
  logic [1:0]  b_corr_cnt, b_uerr_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic rand_rdy = 1'b0;

  logic [EXP_W-1:0] exp_q[$];
  int m16_corr = 0, m16_uerr = 0, m2_corr = 0, m2_uerr = 0;

  always #5 clk = ~clk;

  dec_secded_32 #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_corr(out_corr), .out_uerr(out_uerr),
    .out_pos(out_pos), .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uerr_cnt(uerr_cnt)
  );

  dec_secded_32 #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_code(in_code), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_corr(b_out_corr), .out_uerr(b_out_uerr),
    .out_pos(b_out_pos), .cnt_clr(cnt_clr), .corr_cnt(b_corr_cnt), .uerr_cnt(b_uerr_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] encode(input logic [25:0] d);
    logic [31:0] w;
    logic        par;
    int          k;
    w = '0;
    k = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        w[p] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 5; b++) begin
      par = 1'b0;
      for (int p = 1; p < 32; p++) begin
        if (((p >> b) & 1) == 1 && (p & (p - 1)) != 0) par = par ^ w[p];
      end
      w[1 << b] = par;
    end
    w[0] = ^w[31:1];
    return w;
  endfunction

  function automatic logic [25:0] extract(input logic [31:0] w);
    logic [25:0] d;
    int          k;
    d = '0;
    k = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = w[p];
        k++;
      end
    end
    return d;
  endfunction

  // Decode by searching for the nearest valid codeword.
  function automatic logic [EXP_W-1:0] ref_decode(input logic [31:0] w, input logic e);
    logic [31:0] t;
    if (!e || encode(extract(w)) == w) return {extract(w), 1'b0, 1'b0, 5'd0};
    for (int b = 0; b < 32; b++) begin
      t = w ^ (32'd1 << b);
      if (encode(extract(t)) == t) return {extract(t), 1'b1, 1'b0, 5'(b)};
    end
    return {extract(w), 1'b0, 1'b1, 5'd0};
  endfunction

  function automatic int sat_inc(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin : mon
    logic [EXP_W-1:0] e, cur, prev_out;
    logic hold_prev, got_e;
    hold_prev = 1'b0;
    prev_out  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 1'b0;
      end else begin
        cur = {out_data, out_corr, out_uerr, out_pos};
        check("in_ready", in_ready, out_valid ? out_ready : 1'b1);
        if (hold_prev) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_out", cur, prev_out);
        end
        check("corr_cnt16", corr_cnt, m16_corr);
        check("uerr_cnt16", uerr_cnt, m16_uerr);
        check("corr_cnt2", b_corr_cnt, m2_corr);
        check("uerr_cnt2", b_uerr_cnt, m2_uerr);
        got_e = 1'b0;
        e = '0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            got_e = 1'b1;
            check("out", cur, e);
          end
        end
        if (cnt_clr) begin
          m16_corr = 0; m16_uerr = 0; m2_corr = 0; m2_uerr = 0;
        end else if (got_e) begin
          if (e[6]) begin m16_corr = sat_inc(m16_corr, 65535); m2_corr = sat_inc(m2_corr, 3); end
          if (e[5]) begin m16_uerr = sat_inc(m16_uerr, 65535); m2_uerr = sat_inc(m2_uerr, 3); end
        end
        hold_prev = out_valid && !out_ready;
        prev_out  = cur;
        if (in_valid && in_ready) exp_q.push_back(ref_decode(in_code, en));
      end
    end
  end

  initial begin : rdy_gen
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] c, input logic e);
    int t;
    in_code  = c;
    en       = e;
    in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 200);
    if (!in_ready) check("send_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int b1, b2, r;
    w = encode(26'($urandom));
    r = $urandom_range(0, 9);
    b1 = $urandom_range(0, 31);
    b2 = (b1 + $urandom_range(1, 31)) % 32;
    if (r >= 4) w = w ^ (32'd1 << b1);
    if (r >= 7) w = w ^ (32'd1 << b2);
    if (r == 9) w = $urandom;
    return w;
  endfunction

  // ---------------- main sequence ----------------
  initial begin : main
    int cyc;
    int saved_corr, saved_uerr;
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_code = '0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 26'd0);
    check("rst_flags", {out_corr, out_uerr, out_pos}, 7'd0);
    check("rst_cnts", {corr_cnt, uerr_cnt}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Latency of a single clean word.
    in_code = 32'h0; en = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) break;
    end
    check("latency", cyc, 2);
    drain();

    // Directed test-plan codewords, streamed back-to-back.
    send_word(32'h0000_000F, 1'b1);
    send_word(32'h0000_0007, 1'b1);
    send_word(32'h0000_0001, 1'b1);
    send_word(32'h0000_0027, 1'b1);
    drain();
    check("dir_corr_cnt", corr_cnt, 16'd2);
    check("dir_uerr_cnt", uerr_cnt, 16'd1);

    // Pass-through: counters must not move.
    saved_corr = m16_corr;
    saved_uerr = m16_uerr;
    send_word(32'h0000_0007, 1'b0);
    drain();
    check("en0_corr_cnt", corr_cnt, saved_corr);
    check("en0_uerr_cnt", uerr_cnt, saved_uerr);

    // Backpressure: 3-cycle stall in the middle of a 4-word stream.
    fork
      begin
        for (int i = 0; i < 4; i++) send_word(rand_word(), 1'b1);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("stall_in_ready", in_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Saturation of the 2-bit counter.
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) send_word(32'h0000_0007, 1'b1);
    drain();
    check("sat_cnt2", b_corr_cnt, 2'd3);
    check("sat_cnt16", corr_cnt, 16'd5);

    // Clear coinciding with a corrected handshake.
    out_ready = 1'b0;
    send_word(32'h0000_0007, 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("clr_wait", out_valid, 1'b1);
    out_ready = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    @(negedge clk);
    check("clr_win16", corr_cnt, 16'd0);
    check("clr_win2", b_corr_cnt, 2'd0);
    drain();

    // Random traffic with random backpressure and enable.
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) send_word(rand_word(), ($urandom_range(0, 7) != 0));
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset while the pipeline holds data.
    out_ready = 1'b0;
    send_word(rand_word(), 1'b1);
    send_word(rand_word(), 1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    m16_corr = 0; m16_uerr = 0; m2_corr = 0; m2_uerr = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("postrst_in_ready", in_ready, 1'b1);
    check("postrst_out_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_word(32'h0000_0007, 1'b1);
    send_word(rand_word(), 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
